// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC     = 3'd2,
    FPU_WAIT = 3'd3,
    MEM      = 3'd4,
    WB       = 3'd5
  } seq_state_t;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

  localparam int unsigned INSTR_W = 32;

  // States in which the sequencer waits on an external completion signal.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == FPU_WAIT) || (s == MEM);
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Counts cycles spent waiting on memory or the FPU; flags expiry on the last allowed cycle.
module wait_watchdog #(
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd;

  // Wait-cycle counter: cleared on the cycle before entering a wait state, saturates at the last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
    end else if (clear) begin
      wd <= '0;
    end else if (enable && (wd != LAST)) begin
      wd <= wd + WD_W'(1);
    end
  end

  assign expired = enable && (wd == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: owns the instruction register and turns static decoder
// control bits into per-cycle fetch, PC, memory, FPU and register-file strobes.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] ir_out,
  input  logic               dec_reg_wr,
  input  logic               dec_f_reg_wr,
  input  logic               dec_branch,
  input  logic               dec_jump,
  input  logic               dec_mem_wr,
  input  logic               dec_mem_rd,
  input  logic               dec_fpu_op,
  input  logic               branch_cond,
  input  logic               dmem_ready,
  input  logic               fpu_done,
  output logic               imem_req,
  output logic               pc_wr,
  output logic               pc_sel,
  output logic               dmem_req,
  output logic               dmem_wr,
  output logic               fpu_start,
  output logic               reg_wr_en,
  output logic               f_reg_wr_en,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired,
  output logic               timeout_err
);

  seq_state_t state_q;
  logic       wd_expired;
  logic       target_taken;

  assign state        = state_q;
  assign target_taken = !dec_fpu_op && (dec_jump || (dec_branch && branch_cond));

  wait_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q == EXEC),
    .enable (is_wait_state(state_q)),
    .expired(wd_expired)
  );

  // PC strobes: fetch acceptance and taken branch/jump resolve in the cycle they occur.
  always_comb begin
    pc_wr  = 1'b0;
    pc_sel = PC_SEL_SEQ;
    if (state_q == FETCH) begin
      pc_wr = imem_req && imem_ready;
    end else if ((state_q == EXEC) && target_taken) begin
      pc_wr  = 1'b1;
      pc_sel = PC_SEL_TGT;
    end
  end

  // Sequencer FSM; remaining strobes are registered against the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      ir_out      <= '0;
      retired     <= '0;
      timeout_err <= 1'b0;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_wr     <= 1'b0;
      fpu_start   <= 1'b0;
      reg_wr_en   <= 1'b0;
      f_reg_wr_en <= 1'b0;
    end else begin
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_wr     <= 1'b0;
      fpu_start   <= 1'b0;
      reg_wr_en   <= 1'b0;
      f_reg_wr_en <= 1'b0;
      unique case (state_q)
        FETCH: begin
          if (imem_req && imem_ready) begin
            ir_out  <= instr_in;
            state_q <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          state_q   <= EXEC;
          fpu_start <= dec_fpu_op;
        end
        EXEC: begin
          if (dec_fpu_op) begin
            state_q <= FPU_WAIT;
          end else if (dec_mem_wr || dec_mem_rd) begin
            state_q  <= MEM;
            dmem_req <= 1'b1;
            dmem_wr  <= dec_mem_wr;
          end else if (dec_reg_wr || dec_f_reg_wr) begin
            state_q     <= WB;
            reg_wr_en   <= dec_reg_wr;
            f_reg_wr_en <= dec_f_reg_wr;
          end else begin
            state_q  <= FETCH;
            imem_req <= 1'b1;
            retired  <= retired + CNT_W'(1);
          end
        end
        FPU_WAIT: begin
          if (fpu_done) begin
            state_q     <= WB;
            reg_wr_en   <= dec_reg_wr;
            f_reg_wr_en <= dec_f_reg_wr;
          end else if (wd_expired) begin
            state_q     <= FETCH;
            imem_req    <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            if (dec_mem_rd) begin
              state_q     <= WB;
              reg_wr_en   <= dec_reg_wr;
              f_reg_wr_en <= dec_f_reg_wr;
            end else begin
              state_q  <= FETCH;
              imem_req <= 1'b1;
              retired  <= retired + CNT_W'(1);
            end
          end else if (wd_expired) begin
            state_q     <= FETCH;
            imem_req    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            dmem_req <= 1'b1;
            dmem_wr  <= dec_mem_wr;
          end
        end
        WB: begin
          state_q  <= FETCH;
          imem_req <= 1'b1;
          retired  <= retired + CNT_W'(1);
        end
        default: begin
          state_q  <= FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;

  localparam int unsigned WD = 8;
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_F  = 3'd0;
  localparam logic [2:0] S_D  = 3'd1;
  localparam logic [2:0] S_E  = 3'd2;
  localparam logic [2:0] S_FW = 3'd3;
  localparam logic [2:0] S_M  = 3'd4;
  localparam logic [2:0] S_WB = 3'd5;

  logic          clk;
  logic          reset_n;
  logic          imem_ready;
  logic [31:0]   instr_in;
  logic [31:0]   ir_out;
  logic          dec_reg_wr, dec_f_reg_wr, dec_branch, dec_jump;
  logic          dec_mem_wr, dec_mem_rd, dec_fpu_op;
  logic          branch_cond, dmem_ready, fpu_done;
  logic          imem_req, pc_wr, pc_sel, dmem_req, dmem_wr, fpu_start, reg_wr_en, f_reg_wr_en;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic          timeout_err;

  // {imem_req, pc_wr, pc_sel, dmem_req, dmem_wr, fpu_start, reg_wr_en, f_reg_wr_en}
  logic [7:0]    strb;
  assign strb = {imem_req, pc_wr, pc_sel, dmem_req, dmem_wr, fpu_start, reg_wr_en, f_reg_wr_en};

  int            passed = 0;
  int            total  = 0;
  logic [CW-1:0] exp_ret;

  multicycle_sequencer #(
    .WATCHDOG_CYCLES(WD),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_ready  (imem_ready),
    .instr_in    (instr_in),
    .ir_out      (ir_out),
    .dec_reg_wr  (dec_reg_wr),
    .dec_f_reg_wr(dec_f_reg_wr),
    .dec_branch  (dec_branch),
    .dec_jump    (dec_jump),
    .dec_mem_wr  (dec_mem_wr),
    .dec_mem_rd  (dec_mem_rd),
    .dec_fpu_op  (dec_fpu_op),
    .branch_cond (branch_cond),
    .dmem_ready  (dmem_ready),
    .fpu_done    (fpu_done),
    .imem_req    (imem_req),
    .pc_wr       (pc_wr),
    .pc_sel      (pc_sel),
    .dmem_req    (dmem_req),
    .dmem_wr     (dmem_wr),
    .fpu_start   (fpu_start),
    .reg_wr_en   (reg_wr_en),
    .f_reg_wr_en (f_reg_wr_en),
    .state       (state),
    .retired     (retired),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_dec(input logic rw, input logic frw, input logic br, input logic jp,
                         input logic mw, input logic mr, input logic fp);
    dec_reg_wr = rw; dec_f_reg_wr = frw; dec_branch = br; dec_jump = jp;
    dec_mem_wr = mw; dec_mem_rd = mr; dec_fpu_op = fp;
  endtask

  // Starts at a negedge in FETCH with imem_req high; returns at the negedge in EXEC.
  task automatic issue(input logic [31:0] w);
    instr_in = w; imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ready = 1'b0; instr_in = 32'hFFFF_FFFF;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    branch_cond = 1'b0; dmem_ready = 1'b0; fpu_done = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (state !== S_F) $display("FAIL reset_state: got %0d want %0d", state, S_F); else passed++;
    total++; if (ir_out !== 32'h0) $display("FAIL reset_ir: got %h want %h", ir_out, 32'h0); else passed++;
    total++; if (retired !== 4'd0) $display("FAIL reset_retired: got %0d want 0", retired); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err); else passed++;
    total++; if (strb !== 8'h00) $display("FAIL reset_strobes: got %b want %b", strb, 8'h00); else passed++;
    reset_n = 1'b1;
    #1;
    total++; if (strb !== 8'h00) $display("FAIL reset_release_strobes: got %b want %b", strb, 8'h00); else passed++;
    @(negedge clk);
    total++; if ({state, strb} !== {S_F, 8'h80}) $display("FAIL reset_first_req: got %0d/%b want %0d/%b", state, strb, S_F, 8'h80); else passed++;
    exp_ret = '0;
  endtask

  task automatic test_add();
    set_dec(1, 0, 0, 0, 0, 0, 0);
    instr_in = 32'h0022_1820; imem_ready = 1'b1;
    #1;
    total++; if (strb !== 8'hC0) $display("FAIL add_fetch_pc: got %b want %b", strb, 8'hC0); else passed++;
    @(negedge clk); imem_ready = 1'b0;
    total++; if ({state, strb} !== {S_D, 8'h00}) $display("FAIL add_decode: got %0d/%b want %0d/%b", state, strb, S_D, 8'h00); else passed++;
    total++; if (ir_out !== 32'h0022_1820) $display("FAIL add_ir: got %h want %h", ir_out, 32'h0022_1820); else passed++;
    @(negedge clk);
    total++; if ({state, strb} !== {S_E, 8'h00}) $display("FAIL add_exec: got %0d/%b want %0d/%b", state, strb, S_E, 8'h00); else passed++;
    @(negedge clk);
    total++; if ({state, strb} !== {S_WB, 8'h02}) $display("FAIL add_wb: got %0d/%b want %0d/%b", state, strb, S_WB, 8'h02); else passed++;
    total++; if (retired !== exp_ret) $display("FAIL add_retired_before: got %0d want %0d", retired, exp_ret); else passed++;
    @(negedge clk); exp_ret++;
    total++; if ({state, strb} !== {S_F, 8'h80}) $display("FAIL add_back_fetch: got %0d/%b want %0d/%b", state, strb, S_F, 8'h80); else passed++;
    total++; if (retired !== exp_ret) $display("FAIL add_retired_after: got %0d want %0d", retired, exp_ret); else passed++;
  endtask

  task automatic test_load();
    set_dec(1, 0, 0, 0, 0, 1, 0);
    issue(32'h8C22_0004);
    total++; if ({state, strb} !== {S_E, 8'h00}) $display("FAIL lw_exec: got %0d/%b want %0d/%b", state, strb, S_E, 8'h00); else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++; if ({state, strb} !== {S_M, 8'h10}) $display("FAIL lw_mem_%0d: got %0d/%b want %0d/%b", i, state, strb, S_M, 8'h10); else passed++;
    end
    dmem_ready = 1'b1;
    @(negedge clk); dmem_ready = 1'b0;
    total++; if ({state, strb} !== {S_WB, 8'h02}) $display("FAIL lw_wb: got %0d/%b want %0d/%b", state, strb, S_WB, 8'h02); else passed++;
    @(negedge clk); exp_ret++;
    total++; if ({state, retired} !== {S_F, exp_ret}) $display("FAIL lw_retire: got %0d/%0d want %0d/%0d", state, retired, S_F, exp_ret); else passed++;
  endtask

  task automatic test_load_at_expiry();
    set_dec(1, 0, 0, 0, 0, 1, 0);
    issue(32'h8C23_0008);
    for (int i = 1; i <= int'(WD); i++) begin
      @(negedge clk);
      total++; if ({state, strb} !== {S_M, 8'h10}) $display("FAIL lwx_mem_%0d: got %0d/%b want %0d/%b", i, state, strb, S_M, 8'h10); else passed++;
    end
    dmem_ready = 1'b1;
    @(negedge clk); dmem_ready = 1'b0;
    total++; if ({state, strb, timeout_err} !== {S_WB, 8'h02, 1'b0}) $display("FAIL lwx_ready_wins: got %0d/%b/%b want %0d/%b/0", state, strb, timeout_err, S_WB, 8'h02); else passed++;
    @(negedge clk); exp_ret++;
    total++; if ({state, retired} !== {S_F, exp_ret}) $display("FAIL lwx_retire: got %0d/%0d want %0d/%0d", state, retired, S_F, exp_ret); else passed++;
  endtask

  task automatic test_store();
    set_dec(0, 0, 0, 0, 1, 0, 0);
    issue(32'hAC22_0004);
    @(negedge clk);
    total++; if ({state, strb} !== {S_M, 8'h18}) $display("FAIL sw_mem: got %0d/%b want %0d/%b", state, strb, S_M, 8'h18); else passed++;
    dmem_ready = 1'b1;
    @(negedge clk); dmem_ready = 1'b0; exp_ret++;
    total++; if ({state, strb, retired} !== {S_F, 8'h80, exp_ret}) $display("FAIL sw_done: got %0d/%b/%0d want %0d/%b/%0d", state, strb, retired, S_F, 8'h80, exp_ret); else passed++;
  endtask

  task automatic test_branch();
    set_dec(0, 0, 1, 0, 0, 0, 0);
    branch_cond = 1'b1;
    issue(32'h1020_0010);
    total++; if ({state, strb} !== {S_E, 8'h60}) $display("FAIL beqz_taken: got %0d/%b want %0d/%b", state, strb, S_E, 8'h60); else passed++;
    @(negedge clk); exp_ret++; branch_cond = 1'b0;
    total++; if ({state, strb, retired} !== {S_F, 8'h80, exp_ret}) $display("FAIL beqz_taken_retire: got %0d/%b/%0d want %0d/%b/%0d", state, strb, retired, S_F, 8'h80, exp_ret); else passed++;
    issue(32'h1020_0010);
    total++; if ({state, strb} !== {S_E, 8'h00}) $display("FAIL beqz_not_taken: got %0d/%b want %0d/%b", state, strb, S_E, 8'h00); else passed++;
    @(negedge clk); exp_ret++;
    total++; if ({state, retired} !== {S_F, exp_ret}) $display("FAIL beqz_nt_retire: got %0d/%0d want %0d/%0d", state, retired, S_F, exp_ret); else passed++;
  endtask

  task automatic test_jump_link();
    set_dec(1, 0, 0, 1, 0, 0, 0);
    issue(32'h0C00_0040);
    total++; if ({state, strb} !== {S_E, 8'h60}) $display("FAIL jal_exec: got %0d/%b want %0d/%b", state, strb, S_E, 8'h60); else passed++;
    @(negedge clk);
    total++; if ({state, strb} !== {S_WB, 8'h02}) $display("FAIL jal_wb: got %0d/%b want %0d/%b", state, strb, S_WB, 8'h02); else passed++;
    @(negedge clk); exp_ret++;
    total++; if ({state, retired} !== {S_F, exp_ret}) $display("FAIL jal_retire: got %0d/%0d want %0d/%0d", state, retired, S_F, exp_ret); else passed++;
  endtask

  task automatic test_ignored_ready();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    fpu_done = 1'b1; dmem_ready = 1'b1;
    issue(32'h0000_0000);
    total++; if ({state, strb} !== {S_E, 8'h00}) $display("FAIL ign_exec: got %0d/%b want %0d/%b", state, strb, S_E, 8'h00); else passed++;
    @(negedge clk); exp_ret++; fpu_done = 1'b0; dmem_ready = 1'b0;
    total++; if ({state, strb, retired} !== {S_F, 8'h80, exp_ret}) $display("FAIL ign_retire: got %0d/%b/%0d want %0d/%b/%0d", state, strb, retired, S_F, 8'h80, exp_ret); else passed++;
  endtask

  task automatic test_fpu_done();
    set_dec(0, 1, 0, 0, 0, 0, 1);
    issue(32'h0462_0012);
    total++; if ({state, strb} !== {S_E, 8'h04}) $display("FAIL fpu_start: got %0d/%b want %0d/%b", state, strb, S_E, 8'h04); else passed++;
    @(negedge clk);
    total++; if ({state, strb} !== {S_FW, 8'h00}) $display("FAIL fpu_wait1: got %0d/%b want %0d/%b", state, strb, S_FW, 8'h00); else passed++;
    @(negedge clk); fpu_done = 1'b1;
    total++; if ({state, strb} !== {S_FW, 8'h00}) $display("FAIL fpu_wait2: got %0d/%b want %0d/%b", state, strb, S_FW, 8'h00); else passed++;
    @(negedge clk); fpu_done = 1'b0;
    total++; if ({state, strb} !== {S_WB, 8'h01}) $display("FAIL fpu_wb: got %0d/%b want %0d/%b", state, strb, S_WB, 8'h01); else passed++;
    @(negedge clk); exp_ret++;
    total++; if ({state, retired} !== {S_F, exp_ret}) $display("FAIL fpu_retire: got %0d/%0d want %0d/%0d", state, retired, S_F, exp_ret); else passed++;
  endtask

  task automatic test_fpu_timeout();
    set_dec(0, 1, 0, 0, 0, 0, 1);
    issue(32'h0462_0012);
    total++; if ({state, strb} !== {S_E, 8'h04}) $display("FAIL mult_start: got %0d/%b want %0d/%b", state, strb, S_E, 8'h04); else passed++;
    for (int i = 1; i <= int'(WD); i++) begin
      @(negedge clk);
      total++; if ({state, strb, timeout_err} !== {S_FW, 8'h00, 1'b0}) $display("FAIL mult_wait_%0d: got %0d/%b/%b want %0d/%b/0", i, state, strb, timeout_err, S_FW, 8'h00); else passed++;
    end
    @(negedge clk);
    total++; if ({state, strb, timeout_err} !== {S_F, 8'h80, 1'b1}) $display("FAIL mult_abort: got %0d/%b/%b want %0d/%b/1", state, strb, timeout_err, S_F, 8'h80); else passed++;
    total++; if (retired !== exp_ret) $display("FAIL mult_no_retire: got %0d want %0d", retired, exp_ret); else passed++;
  endtask

  task automatic test_reset_in_mem();
    set_dec(1, 0, 0, 0, 0, 1, 0);
    issue(32'h8C24_000C);
    @(negedge clk);
    total++; if ({state, strb} !== {S_M, 8'h10}) $display("FAIL rst_mem_entry: got %0d/%b want %0d/%b", state, strb, S_M, 8'h10); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (strb !== 8'h00) $display("FAIL rst_mem_strobes: got %b want %b", strb, 8'h00); else passed++;
    total++; if ({state, ir_out} !== {S_F, 32'h0}) $display("FAIL rst_mem_state_ir: got %0d/%h want %0d/%h", state, ir_out, S_F, 32'h0); else passed++;
    total++; if ({retired, timeout_err} !== {4'd0, 1'b0}) $display("FAIL rst_mem_counters: got %0d/%b want 0/0", retired, timeout_err); else passed++;
    @(negedge clk); reset_n = 1'b1; exp_ret = '0;
    @(negedge clk);
    total++; if ({state, strb, retired} !== {S_F, 8'h80, 4'd0}) $display("FAIL rst_mem_release: got %0d/%b/%0d want %0d/%b/0", state, strb, retired, S_F, 8'h80); else passed++;
  endtask

  task automatic test_retire_wrap();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 16; n++) begin
      issue(32'h0000_0000);
      @(negedge clk); exp_ret++;
      total++; if (retired !== exp_ret) $display("FAIL wrap_%0d: got %0d want %0d", n, retired, exp_ret); else passed++;
    end
    total++; if (retired !== 4'd0) $display("FAIL wrap_zero: got %0d want 0", retired); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_load_at_expiry();
    test_store();
    test_branch();
    test_jump_link();
    test_ignored_ready();
    test_fpu_done();
    test_fpu_timeout();
    test_reset_in_mem();
    test_retire_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
